ifetch_unit: RTL and testbench

Instruction fetch front end that sits directly upstream of the instruction-cache top: it generates the PC stream, drives the cache's CPU-side read/address/busywait handshake, and buffers returned instructions with their PCs in a small FIFO for decode. It also accepts branch/jump redirects, flushing buffered instructions. A redirect arriving during an outstanding cache miss is deferred until the miss completes.

---
 rtl/ifetch_unit.sv | 149 ++++++++++++++
 tb/tb_ifetch_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: drives the I-cache CPU-side handshake, buffers
// fetched {pc, instr} pairs for decode and applies (possibly deferred) redirects.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        cpu_read,
  output logic [31:0] cpu_addr,
  input  logic [31:0] cpu_instr,
  input  logic        cpu_busywait,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_DISCARD = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   pending_pc_q, pending_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  entry_t            mem_q [FIFO_DEPTH];

  logic              complete_c;
  logic              push_c;
  logic              pop_c;
  logic              flush_c;
  logic [XLEN-1:0]   redir_pc_c;
  entry_t            wr_entry_c;

  // State and FIFO bookkeeping registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // Entry storage carries data only, so it needs no reset
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= wr_entry_c;
    end
  end

  // Next-state: fetch PC, deferred redirect target and FIFO pointers
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    push_c       = 1'b0;
    flush_c      = 1'b0;
    redir_pc_c   = redirect_pc & 32'hFFFF_FFFC;
    complete_c   = cpu_read & ~cpu_busywait;
    pop_c        = out_valid & out_ready;
    wr_entry_c   = '{pc: fetch_pc_q, instr: cpu_instr};

    case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          flush_c = 1'b1;
          // A stalled request cannot be withdrawn: park the target until it completes
          if (cpu_read && cpu_busywait) begin
            pending_pc_d = redir_pc_c;
            state_d      = ST_DISCARD;
          end else begin
            fetch_pc_d = redir_pc_c;
          end
        end else if (complete_c) begin
          push_c     = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      ST_DISCARD: begin
        if (redirect_valid) begin
          flush_c      = 1'b1;
          pending_pc_d = redir_pc_c;
        end
        if (complete_c) begin
          fetch_pc_d = redirect_valid ? redir_pc_c : pending_pc_q;
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (flush_c) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Outputs decoded from registered state; reset forces the request low at once
  always_comb begin
    cpu_read  = 1'b0;
    cpu_addr  = fetch_pc_q;
    out_valid = (count_q != '0);
    out_pc    = mem_q[rd_ptr_q].pc;
    out_instr = mem_q[rd_ptr_q].instr;
    if (reset) begin
      cpu_read = (state_q == ST_DISCARD) || (count_q < CNT_W'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed vector table, reset corner sequence and a
// randomized run checked against a queue-based fetch model.
module tb_ifetch_unit;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_instr;
  logic        cpu_busywait;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  int total;
  int bad;

  ifetch_unit #(
    .RESET_PC  (RST_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_read      (cpu_read),
    .cpu_addr      (cpu_addr),
    .cpu_instr     (cpu_instr),
    .cpu_busywait  (cpu_busywait),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  // Cache contents: a fixed scramble of the address
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign cpu_instr = instr_of(cpu_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rdy, input logic bw, input logic rv, input logic [31:0] rpc);
    out_ready      = rdy;
    cpu_busywait   = bw;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  typedef struct {
    logic        ready;
    logic        bw;
    logic        redir;
    logic [31:0] rpc;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rdy, input logic bw, input logic rv,
                              input logic [31:0] rpc, input logic e_read,
                              input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_pc);
    vec_t v;
    v.ready = rdy; v.bw = bw; v.redir = rv; v.rpc = rpc;
    v.e_read = e_read; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  // Reference model: PC stream plus a queue of buffered fetches
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_pend;
  bit          m_disc;

  task automatic model_check_step(input logic rdy, input logic bw, input logic rv,
                                  input logic [31:0] rpc);
    logic        e_read;
    logic        complete;
    logic [31:0] tgt;
    e_read   = m_disc || (m_q.size() < DEPTH);
    complete = e_read && !bw;
    tgt      = {rpc[31:2], 2'b00};
    check("rnd_read", 32'(cpu_read), 32'(e_read));
    check("rnd_addr", cpu_addr, m_fetch);
    check("rnd_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("rnd_pc", out_pc, m_q[0].pc);
      check("rnd_instr", out_instr, m_q[0].ins);
    end
    if (m_disc) begin
      if (rv) m_pend = tgt;
      if (complete) begin
        m_fetch = rv ? tgt : m_pend;
        m_disc  = 1'b0;
      end
    end else if (rv) begin
      m_q.delete();
      if (e_read && bw) begin
        m_pend = tgt;
        m_disc = 1'b1;
      end else begin
        m_fetch = tgt;
      end
    end else begin
      if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
      if (complete) begin
        m_q.push_back('{pc: m_fetch, ins: instr_of(m_fetch)});
        m_fetch = m_fetch + 32'd4;
      end
    end
  endtask

  initial begin
    logic        rdy;
    logic        bw;
    logic        rv;
    logic [31:0] rpc;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    // ready, bw, redirect, rpc | read, addr, valid, pc (one row per cycle)
    vecs.push_back(mk(1,0,0,32'h0,         1,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,0,32'h0,         1,32'h4,        1,32'h0));
    vecs.push_back(mk(1,0,0,32'h0,         1,32'h8,        1,32'h4));
    vecs.push_back(mk(1,0,0,32'h0,         1,32'hC,        1,32'h8));
    vecs.push_back(mk(0,0,0,32'h0,         1,32'h10,       1,32'hC));
    vecs.push_back(mk(0,0,0,32'h0,         1,32'h14,       1,32'hC));
    vecs.push_back(mk(0,0,0,32'h0,         1,32'h18,       1,32'hC));
    vecs.push_back(mk(0,0,0,32'h0,         0,32'h1C,       1,32'hC));
    vecs.push_back(mk(1,0,0,32'h0,         0,32'h1C,       1,32'hC));
    vecs.push_back(mk(1,0,0,32'h0,         1,32'h1C,       1,32'h10));
    vecs.push_back(mk(1,1,0,32'h0,         1,32'h20,       1,32'h14));
    vecs.push_back(mk(1,1,0,32'h0,         1,32'h20,       1,32'h18));
    vecs.push_back(mk(1,1,0,32'h0,         1,32'h20,       1,32'h1C));
    vecs.push_back(mk(1,1,0,32'h0,         1,32'h20,       0,32'h0));
    vecs.push_back(mk(1,1,0,32'h0,         1,32'h20,       0,32'h0));
    vecs.push_back(mk(1,0,0,32'h0,         1,32'h20,       0,32'h0));
    vecs.push_back(mk(0,1,0,32'h0,         1,32'h24,       1,32'h20));
    vecs.push_back(mk(0,1,1,32'h100,       1,32'h24,       1,32'h20));
    vecs.push_back(mk(0,1,0,32'h0,         1,32'h24,       0,32'h0));
    vecs.push_back(mk(1,0,0,32'h0,         1,32'h24,       0,32'h0));
    vecs.push_back(mk(1,0,0,32'h0,         1,32'h100,      0,32'h0));
    vecs.push_back(mk(1,0,1,32'h203,       1,32'h104,      1,32'h100));
    vecs.push_back(mk(1,0,0,32'h0,         1,32'h200,      0,32'h0));
    vecs.push_back(mk(1,0,1,32'hFFFF_FFFF, 1,32'h204,      1,32'h200));
    vecs.push_back(mk(1,0,0,32'h0,         1,32'hFFFF_FFFC,0,32'h0));
    vecs.push_back(mk(1,0,0,32'h0,         1,32'h0,        1,32'hFFFF_FFFC));
    vecs.push_back(mk(1,1,0,32'h0,         1,32'h4,        1,32'h0));
    vecs.push_back(mk(1,1,1,32'h300,       1,32'h4,        0,32'h0));
    vecs.push_back(mk(1,1,1,32'h400,       1,32'h4,        0,32'h0));
    vecs.push_back(mk(1,0,1,32'h500,       1,32'h4,        0,32'h0));
    vecs.push_back(mk(1,0,0,32'h0,         1,32'h500,      0,32'h0));
    vecs.push_back(mk(1,1,0,32'h0,         1,32'h504,      1,32'h500));
    vecs.push_back(mk(1,1,1,32'h600,       1,32'h504,      0,32'h0));
    vecs.push_back(mk(1,0,0,32'h0,         1,32'h504,      0,32'h0));
    vecs.push_back(mk(1,0,0,32'h0,         1,32'h600,      0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,         1,32'h604,      1,32'h600));

    repeat (2) @(negedge clk);
    #1;
    check("reset_read", 32'(cpu_read), 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i].ready, vecs[i].bw, vecs[i].redir, vecs[i].rpc);
      #1;
      check($sformatf("vec%0d_read", i), 32'(cpu_read), 32'(vecs[i].e_read));
      check($sformatf("vec%0d_addr", i), cpu_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_pc", i), out_pc, vecs[i].e_pc);
        check($sformatf("vec%0d_instr", i), out_instr, instr_of(vecs[i].e_pc));
      end
    end

    // Asynchronous reset in the middle of a miss with the FIFO occupied
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    check("premiss_valid", 32'(out_valid), 32'h1);
    check("premiss_addr", cpu_addr, 32'h608);
    #2;
    reset = 1'b0;
    #1;
    check("midmiss_rst_read", 32'(cpu_read), 32'h0);
    check("midmiss_rst_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    check("restart_read", 32'(cpu_read), 32'h1);
    check("restart_addr", cpu_addr, RST_PC);
    check("restart_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    #1;
    check("restart_addr2", cpu_addr, RST_PC + 32'd4);
    check("restart_pc", out_pc, RST_PC);
    check("restart_instr", out_instr, instr_of(RST_PC));

    // Randomized run against the reference model
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b1;
    m_fetch = RST_PC;
    m_pend  = RST_PC;
    m_disc  = 1'b0;
    m_q.delete();
    for (int n = 0; n < 3000; n++) begin
      if (n > 0) @(negedge clk);
      if (((n / 200) % 2) != 0) rdy = ($urandom_range(0, 3) != 0);
      else                      rdy = ($urandom_range(0, 3) == 0);
      bw  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | {28'h0, rpc[3:0]};
      drive(rdy, bw, rv, rpc);
      #1;
      model_check_step(rdy, bw, rv, rpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
